// File: rtl/gray_ptr_ctrl_pkg.sv
// Shared constants for the async-FIFO pointer controller.
// A pointer carries one wrap bit above the RAM address, so it is one bit wider than the address.
package gray_ptr_ctrl_pkg;

    localparam int SIDE_WR = 0;
    localparam int SIDE_RD = 1;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bin_to_gray_gen.sv
// Library binary-to-Gray converter for a DATA_WIDTH-bit address plus its wrap bit.
module bin_to_gray_gen #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH:0] bin,
    output logic [DATA_WIDTH:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_ptr_ctrl_sync.sv
// Multi-flop synchronizer for the Gray pointer arriving from the other clock domain.
// All bits move in parallel with no logic between stages; Gray coding keeps the sampled value coherent.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the remote pointer through the flop chain, clearing every stage on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_to_bin_gen.sv
// Library Gray-to-binary converter for a DATA_WIDTH-bit address plus its wrap bit.
module gray_to_bin_gen #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH:0] gray,
    output logic [DATA_WIDTH:0] bin
);

    // Each binary bit is the parity of the Gray bits at and above its position
    always_comb begin
        bin = '0;
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async-FIFO pointer pair: local pointer counter, remote pointer
// synchronizer and registered full/empty flag plus occupancy level.
// SIDE selects write behaviour (full flag) or read behaviour (empty flag).
module gray_ptr_ctrl
    import gray_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SIDE        = SIDE_WR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_en,
    input  logic [ADDR_WIDTH:0]   remote_gray_ptr,
    output logic                  inc_ok,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   local_gray_ptr,
    output logic [ADDR_WIDTH:0]   local_bin_ptr,
    output logic                  flag,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);

    // Full means the local pointer has lapped the remote one: the top two Gray bits differ, the rest match
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    // A read side comes out of reset empty; a write side comes out not full
    localparam logic FLAG_RESET = (SIDE == SIDE_RD);

    logic [PTR_W-1:0] bin_ptr;
    logic [PTR_W-1:0] gray_ptr;
    logic [PTR_W-1:0] bin_nxt;
    logic [PTR_W-1:0] gray_nxt;
    logic [PTR_W-1:0] rsync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] level_nxt;
    logic [PTR_W-1:0] level_q;
    logic             flag_q;
    logic             flag_nxt;

    assign inc_ok  = inc_en & ~flag_q;
    assign bin_nxt = bin_ptr + {{(PTR_W-1){1'b0}}, inc_ok};

    bin_to_gray_gen #(
        .DATA_WIDTH (ADDR_WIDTH)
    ) u_bin_to_gray (
        .bin  (bin_nxt),
        .gray (gray_nxt)
    );

    gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (remote_gray_ptr),
        .q     (rsync)
    );

    gray_to_bin_gen #(
        .DATA_WIDTH (ADDR_WIDTH)
    ) u_gray_to_bin (
        .gray (rsync),
        .bin  (rbin)
    );

    if (SIDE == SIDE_WR) begin : g_write_side
        assign flag_nxt  = (gray_nxt == (rsync ^ FULL_MASK));
        assign level_nxt = bin_nxt - rbin;
    end else begin : g_read_side
        assign flag_nxt  = (gray_nxt == rsync);
        assign level_nxt = rbin - bin_nxt;
    end

    // Register pointers, flag and level from next-state values so all outputs are glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_ptr  <= '0;
            gray_ptr <= '0;
            level_q  <= '0;
            flag_q   <= FLAG_RESET;
        end else begin
            bin_ptr  <= bin_nxt;
            gray_ptr <= gray_nxt;
            level_q  <= level_nxt;
            flag_q   <= flag_nxt;
        end
    end

    assign addr           = bin_ptr[ADDR_WIDTH-1:0];
    assign local_gray_ptr = gray_ptr;
    assign local_bin_ptr  = bin_ptr;
    assign flag           = flag_q;
    assign level          = level_q;

endmodule

// File: doc/gray_ptr_ctrl.md
Name: gray_ptr_ctrl

Overview:
- One side of an async-FIFO pointer pair: local binary/Gray pointer counter, synchronizer for the remote Gray pointer, Gray-to-binary conversion, and registered full/empty and level.
- Instantiated twice per async FIFO: once as write side in the write domain, once as read side in the read domain.
- Generalises the plain Gray/binary converters with side mode, synchronizer depth, and occupancy tracking.

Parameters:
- ADDR_WIDTH, 4, FIFO address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range ≥1.
- SYNC_STAGES, 2, flops in the remote-pointer synchronizer; legal range ≥2.
- SIDE, 0, 0 = write side (full flag), 1 = read side (empty flag).

Ports:
- clk  in  1  local domain clock
- rst_n  in  1  asynchronous active-low reset
- inc_en  in  1  push request (write side) or pop request (read side)
- remote_gray_ptr  in  ADDR_WIDTH+1  Gray pointer from the other clock domain
- inc_ok  out  1  combinational; request accepted this cycle
- addr  out  ADDR_WIDTH  RAM address: local binary pointer without its MSB
- local_gray_ptr  out  ADDR_WIDTH+1  registered Gray pointer, sent to the other domain
- local_bin_ptr  out  ADDR_WIDTH+1  registered binary pointer
- flag  out  1  full (SIDE=0) or empty (SIDE=1), registered
- level  out  ADDR_WIDTH+1  registered occupancy, range 0..2**ADDR_WIDTH

Behaviour:
- Single clock clk. Asynchronous active-low reset rst_n.
- Reset values:
  - bin/gray pointers = 0; all synchronizer flops = 0; level = 0.
  - flag = 0 when SIDE=0; flag = 1 when SIDE=1.
- Acceptance: inc_ok = inc_en & ~flag. A request while flag is set is dropped; no pointer change, no error.
- Next pointer:
  - bin_nxt = bin_ptr + inc_ok, modulo 2**(ADDR_WIDTH+1); wraps naturally.
  - gray_nxt = bin_nxt ^ (bin_nxt >> 1).
  - Both pointers are registered every cycle, so local_gray_ptr changes by exactly one bit per accepted request.
- Remote pointer path:
  - remote_gray_ptr passes through SYNC_STAGES flops, all ADDR_WIDTH+1 bits in parallel, with no logic between flops.
  - The synchronized value is converted to binary rbin, bit i = XOR of bits ≥ i.
- Flag, registered from next-state values:
  - SIDE=0: full_nxt = (gray_nxt == {~rsync[MSB:MSB-1], rsync[MSB-2:0]}). For ADDR_WIDTH=1 both bits are inverted.
  - SIDE=1: empty_nxt = (gray_nxt == rsync).
- Level, registered:
  - SIDE=0: bin_nxt − rbin.
  - SIDE=1: rbin − bin_nxt.
  - Both are modulo ADDR_WIDTH+1 bits.
- Latency:
  - Local accept: reflected in pointers, flag and level on the next edge (1 cycle).
  - Remote pointer change: reflected in flag/level SYNC_STAGES+1 edges after it is stable on the input.
  - Flags are therefore pessimistic: full and empty may stay set longer than the true state, but are never cleared early.
- Simultaneous local accept and remote change: both are used in the same next-state evaluation; no priority is needed.
- Reset mid-operation: all outputs go to reset values immediately on rst_n falling, independent of clk. Release must be synchronized outside this block.

Decomposition:
- Shared package/header: SIDE_WR = 0 and SIDE_RD = 1 constants, plus the pointer width expression ADDR_WIDTH+1.
- Sub-module gray_ptr_sync: SYNC_STAGES-deep, WIDTH-wide flop chain with async reset to 0.
- Conversions reuse the library gray_to_bin_gen and bin_to_gray_gen with DATA_WIDTH = ADDR_WIDTH.

Test Plan:
1. Reset (ADDR_WIDTH=3, SYNC_STAGES=2): rst_n=0 → pointers 0, level 0; flag 0 for SIDE=0, flag 1 for SIDE=1; inc_en=1 has no effect while in reset.
2. Write fill (SIDE=0, remote=0): inc_en held 9 cycles → 8 accepts; local_gray_ptr steps 0,1,3,2,6,7,5,4,C (hex); flag=1 and level=8 after the 8th edge; 9th cycle inc_ok=0 and ptr stays 4'hC.
3. Read drain (SIDE=1): remote_gray_ptr set to 4'h6 (bin 4) → empty=0 and level=4 three edges later; 4 pops → empty=1, local_gray_ptr=4'h6, 5th pop rejected.
4. Wrap-around (SIDE=0): after 8 writes set remote to 4'hC → full clears 3 edges later; 8 more writes → bin ptr wraps to 0, gray 4'h0, full reasserts, level=8.
5. Simultaneous events (SIDE=1, level=1): pop accepted on the same edge the synchronized remote advances by 1 → level stays 1, empty stays 0.
6. Mid-operation reset: at level=5, drop rst_n between edges → all outputs reach reset values before the next clk edge. Assertion throughout all tests: local_gray_ptr Hamming distance per cycle ≤ 1.
